// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: receives a byte stream (count, big-endian words, XOR checksum),
// writes each assembled word to instruction memory and holds the CPU in reset until a load verifies.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [15:0] TIMEOUT   = 16'd50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        cpu_hold,
  output logic        busy,
  output logic        done,
  output logic        error
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DATA  = 2'd2,
    CHECK = 2'd3
  } state_t;

  state_t      r_state;
  logic [7:0]  r_count;
  logic [7:0]  r_wordIdx;
  logic [1:0]  r_byteCnt;
  logic [23:0] r_shift;
  logic [7:0]  r_csum;
  logic [15:0] r_idle;
  logic        r_memWe;
  logic [31:0] r_memAddr;
  logic [31:0] r_memWdata;
  logic        r_cpuHold;
  logic        r_done;
  logic        r_error;

  logic        w_active;
  logic        w_xfer;
  logic [31:0] w_word;
  logic [15:0] w_idleNext;

  assign w_active   = (r_state != IDLE);
  assign w_xfer     = byte_valid && w_active;
  assign w_word     = {r_shift, byte_data};
  assign w_idleNext = r_idle + 16'd1;

  // Word index is 8 bits and the last word is index N-1 (mod 256), so a count of 0 yields 256 words.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_count    <= 8'd0;
      r_wordIdx  <= 8'd0;
      r_byteCnt  <= 2'd0;
      r_shift    <= 24'd0;
      r_csum     <= 8'd0;
      r_idle     <= 16'd0;
      r_memWe    <= 1'b0;
      r_memAddr  <= 32'd0;
      r_memWdata <= 32'd0;
      r_cpuHold  <= 1'b1;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
    end else begin
      r_memWe <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state   <= COUNT;
            r_error   <= 1'b0;
            r_wordIdx <= 8'd0;
            r_byteCnt <= 2'd0;
            r_csum    <= 8'd0;
            r_idle    <= 16'd0;
            r_cpuHold <= 1'b1;
          end
        end
        default: begin
          if (w_xfer) begin
            r_idle <= 16'd0;
            case (r_state)
              COUNT: begin
                r_count <= byte_data;
                r_csum  <= byte_data;
                r_state <= DATA;
              end
              DATA: begin
                r_shift   <= w_word[23:0];
                r_byteCnt <= r_byteCnt + 2'd1;
                r_csum    <= r_csum ^ byte_data;
                if (r_byteCnt == 2'd3) begin
                  r_memWe    <= 1'b1;
                  r_memWdata <= w_word;
                  r_memAddr  <= BASE_ADDR + {22'd0, r_wordIdx, 2'b00};
                  r_wordIdx  <= r_wordIdx + 8'd1;
                  if (r_wordIdx == r_count - 8'd1) begin
                    r_state <= CHECK;
                  end
                end
              end
              CHECK: begin
                if (byte_data == r_csum) begin
                  r_done    <= 1'b1;
                  r_cpuHold <= 1'b0;
                end else begin
                  r_error <= 1'b1;
                end
                r_state <= IDLE;
              end
              default: r_state <= IDLE;
            endcase
          end else if (w_idleNext == TIMEOUT) begin
            r_error <= 1'b1;
            r_idle  <= 16'd0;
            r_state <= IDLE;
          end else begin
            r_idle <= w_idleNext;
          end
        end
      endcase
    end
  end

  assign byte_ready = w_active;
  assign busy       = w_active;
  assign mem_we     = r_memWe;
  assign mem_addr   = r_memAddr;
  assign mem_wdata  = r_memWdata;
  assign cpu_hold   = r_cpuHold;
  assign done       = r_done;
  assign error      = r_error;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of short load sessions plus hand-written timeout,
// reset-abort, start-while-busy and 256-word sequences.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam int          TMO  = 20;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        cpu_hold;
  logic        busy;
  logic        done;
  logic        error;

  imem_loader #(.BASE_ADDR(BASE), .TIMEOUT(16'(TMO))) dut (
    .clk(clk), .reset(reset), .start(start), .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(byte_ready), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  nWords;
    logic [31:0] w0;
    logic [31:0] w1;
    logic [7:0]  csumFlip;
    logic        expDone;
    logic        expError;
    logic        expHold;
  } vec_t;

  int          checks = 0;
  int          failures = 0;
  int          doneCount = 0;
  logic [31:0] wrAddr[$];
  logic [31:0] wrData[$];
  logic [31:0] words[256];
  vec_t        vecs[5];

  // Log every memory write and done pulse, sampled half a cycle after the edge that produced them.
  always @(negedge clk) begin
    if (mem_we) begin
      wrAddr.push_back(mem_addr);
      wrData.push_back(mem_wdata);
    end
    if (done) doneCount++;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic sendByte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    tick();
  endtask

  task automatic clearLog();
    wrAddr.delete();
    wrData.delete();
    doneCount = 0;
  endtask

  function automatic logic [7:0] checksum(input logic [7:0] n, input int nw);
    logic [7:0] c;
    c = n;
    for (int i = 0; i < nw; i++)
      for (int k = 0; k < 4; k++)
        c = c ^ words[i][8*k +: 8];
    return c;
  endfunction

  task automatic checkResetValues(input string tag);
    check({tag, "_byte_ready"}, byte_ready, 0);
    check({tag, "_mem_we"}, mem_we, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_error"}, error, 0);
    check({tag, "_cpu_hold"}, cpu_hold, 1);
  endtask

  task automatic startSession(input string tag);
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, "_start_hold"}, cpu_hold, 1);
    check({tag, "_start_busy"}, busy, 1);
    check({tag, "_start_error_clr"}, error, 0);
  endtask

  task automatic streamWords(input logic [7:0] n, input int nw);
    sendByte(n);
    for (int i = 0; i < nw; i++)
      for (int k = 0; k < 4; k++)
        sendByte(words[i][31-8*k -: 8]);
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    clearLog();
    words[0] = v.w0;
    words[1] = v.w1;
    startSession(tag);
    streamWords(v.nWords, int'(v.nWords));
    sendByte(checksum(v.nWords, int'(v.nWords)) ^ v.csumFlip);
    byte_valid = 1'b0;
    check({tag, "_done"}, done, 32'(v.expDone));
    check({tag, "_error"}, error, 32'(v.expError));
    check({tag, "_hold"}, cpu_hold, 32'(v.expHold));
    check({tag, "_busy_end"}, busy, 0);
    tick();
    check({tag, "_done_pulse_len"}, done, 0);
    check({tag, "_hold_after"}, cpu_hold, 32'(v.expHold));
    check({tag, "_error_sticky"}, error, 32'(v.expError));
  endtask

  task automatic checkOutput(input vec_t v, input int idx);
    string tag;
    tag = $sformatf("vec%0d", idx);
    check({tag, "_nwrites"}, wrAddr.size(), 32'(v.nWords));
    for (int i = 0; i < int'(v.nWords); i++) begin
      if (i < wrAddr.size()) begin
        check($sformatf("%s_addr%0d", tag, i), wrAddr[i], BASE + 32'(4*i));
        check($sformatf("%s_data%0d", tag, i), wrData[i], (i == 0) ? v.w0 : v.w1);
      end
    end
    check({tag, "_ndone"}, doneCount, 32'(v.expDone));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int errs;
    int waited;
    vecs[0] = '{8'd2, 32'h2004_0003, 32'h0c10_0005, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[1] = '{8'd2, 32'h2004_0003, 32'h0c10_0005, 8'h01, 1'b0, 1'b1, 1'b1};
    vecs[2] = '{8'd1, 32'hdead_beef, 32'h0000_0000, 8'h00, 1'b1, 1'b0, 1'b0};
    vecs[3] = '{8'd2, 32'hffff_ffff, 32'h0000_0000, 8'h80, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{8'd2, 32'h1234_5678, 32'h9abc_def0, 8'h00, 1'b1, 1'b0, 1'b0};

    reset = 1'b1;
    start = 1'b0;
    byte_valid = 1'b0;
    byte_data = 8'h00;
    tick();
    tick();
    checkResetValues("reset");
    reset = 1'b0;
    tick();

    // Bytes offered while idle must be refused.
    clearLog();
    byte_valid = 1'b1;
    byte_data  = 8'h55;
    tick();
    tick();
    tick();
    check("idle_byte_ready", byte_ready, 0);
    check("idle_busy", busy, 0);
    check("idle_no_write", wrAddr.size(), 0);
    byte_valid = 1'b0;
    tick();

    for (int i = 0; i < 5; i++) begin
      applyStimulus(vecs[i], i);
      checkOutput(vecs[i], i);
    end

    // start pulsed in the middle of a word is ignored.
    clearLog();
    words[0] = 32'h2004_0003;
    words[1] = 32'h0c10_0005;
    startSession("sbusy");
    sendByte(8'd2);
    sendByte(8'h20);
    start = 1'b1;
    sendByte(8'h04);
    start = 1'b0;
    sendByte(8'h00);
    sendByte(8'h03);
    for (int k = 0; k < 4; k++) sendByte(words[1][31-8*k -: 8]);
    sendByte(checksum(8'd2, 2));
    byte_valid = 1'b0;
    check("sbusy_done", done, 1);
    check("sbusy_nwrites", wrAddr.size(), 2);
    if (wrData.size() == 2) begin
      check("sbusy_data0", wrData[0], 32'h2004_0003);
      check("sbusy_addr1", wrAddr[1], BASE + 32'h4);
    end
    tick();

    // N=0 loads 256 words, last at BASE+0x3FC with no wrap.
    clearLog();
    for (int i = 0; i < 256; i++)
      words[i] = {8'(i), ~8'(i), 8'(i) ^ 8'h5a, 8'hc3};
    startSession("n256");
    streamWords(8'd0, 256);
    sendByte(checksum(8'd0, 256));
    byte_valid = 1'b0;
    check("n256_done", done, 1);
    check("n256_hold", cpu_hold, 0);
    tick();
    check("n256_nwrites", wrAddr.size(), 256);
    errs = 0;
    for (int i = 0; i < wrAddr.size(); i++) begin
      if (wrAddr[i] !== BASE + 32'(4*i) || wrData[i] !== words[i]) errs++;
    end
    check("n256_addr_data_errs", errs, 0);
    if (wrAddr.size() == 256) check("n256_last_addr", wrAddr[255], BASE + 32'h3fc);

    // Stall after the 5th data byte until the idle timeout fires.
    clearLog();
    words[0] = 32'h2004_0003;
    words[1] = 32'h0c10_0005;
    startSession("tmo");
    sendByte(8'd2);
    for (int k = 0; k < 4; k++) sendByte(words[0][31-8*k -: 8]);
    sendByte(words[1][31:24]);
    byte_valid = 1'b0;
    for (int i = 0; i < TMO - 2; i++) tick();
    check("tmo_early_busy", busy, 1);
    check("tmo_early_error", error, 0);
    waited = 0;
    while (error !== 1'b1 && waited < 10) begin
      tick();
      waited++;
    end
    check("tmo_error", error, 1);
    check("tmo_busy", busy, 0);
    check("tmo_hold", cpu_hold, 1);
    check("tmo_nwrites", wrAddr.size(), 1);
    byte_valid = 1'b1;
    byte_data  = 8'haa;
    for (int i = 0; i < 6; i++) tick();
    byte_valid = 1'b0;
    check("tmo_ready_after", byte_ready, 0);
    check("tmo_nwrites_after", wrAddr.size(), 1);
    check("tmo_ndone", doneCount, 0);

    // Reset after 3 data bytes, asserted together with start and byte_valid.
    clearLog();
    startSession("rst");
    sendByte(8'd2);
    sendByte(8'h20);
    sendByte(8'h04);
    sendByte(8'h00);
    reset = 1'b1;
    start = 1'b1;
    byte_valid = 1'b1;
    byte_data = 8'h03;
    tick();
    checkResetValues("rst_mid");
    reset = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    byte_valid = 1'b0;
    check("rst_no_write", wrAddr.size(), 0);
    check("rst_hold", cpu_hold, 1);
    check("rst_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
